// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store initiator for the data-memory port; sub-word
//                stores use read-modify-write, loads extract and extend.
//  Revision    : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int READ_LAT  = 1,
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ce,
    output logic        mem_we,
    output logic        mem_rr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_w_mask,
    output logic [3:0]  mem_r_mask,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_READ      = 2'd1;
    localparam logic [1:0]  c_WRITE     = 2'd2;
    localparam logic [1:0]  c_RESP      = 2'd3;
    localparam logic [1:0]  c_LAT_INIT  = 2'(READ_LAT - 1);
    localparam logic [31:0] c_MEM_LIMIT = 32'(MEM_BYTES);

    logic [1:0]  r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic        r_err;
    logic [1:0]  r_lat_cnt;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_req_err;
    logic        w_live;
    logic        w_in_read;
    logic        w_in_write;
    logic        w_in_resp;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_merged;
    logic [31:0] w_load_data;

    assign w_accept     = req_valid && req_ready;
    assign w_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
    assign w_req_err    = w_misaligned || (req_addr >= c_MEM_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_word     <= 32'h0;
            r_err      <= 1'b0;
            r_lat_cnt  <= 2'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_err      <= w_req_err;
                        r_lat_cnt  <= c_LAT_INIT;
                        if (w_req_err)
                            r_state <= c_RESP;
                        else if (req_we && req_size[1])
                            r_state <= c_WRITE;
                        else
                            r_state <= c_READ;
                    end
                end
                c_READ: begin
                    // Capture only on the final cycle of the read window.
                    if (r_lat_cnt == 2'd0) begin
                        r_word  <= mem_rdata;
                        r_state <= r_we ? c_WRITE : c_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 2'd1;
                    end
                end
                c_WRITE: r_state <= c_RESP;
                c_RESP:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign w_byte = r_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_word[{r_addr[1], 4'b0000} +: 16];

    // Memory masks cover all lanes, so sub-word stores rewrite the whole word.
    always_comb begin
        w_merged = r_word;
        case (r_size)
            2'b00:   w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            2'b01:   w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merged = r_wdata;
        endcase
    end

    always_comb begin
        case (r_size)
            2'b00:   w_load_data = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = r_word;
        endcase
    end

    assign w_live     = !rst;
    assign w_in_read  = w_live && (r_state == c_READ);
    assign w_in_write = w_live && (r_state == c_WRITE);
    assign w_in_resp  = w_live && (r_state == c_RESP);

    assign req_ready  = (r_state == c_IDLE);
    assign mem_ce     = w_in_read || w_in_write;
    assign mem_rr     = w_in_read;
    assign mem_we     = w_in_write;
    assign mem_addr   = mem_ce ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = w_in_write ? w_merged : 32'h0;
    assign mem_w_mask = {4{w_in_write}};
    assign mem_r_mask = {4{w_in_read}};

    assign resp_valid = w_in_resp;
    assign resp_err   = w_in_resp && r_err;
    assign resp_rdata = (w_in_resp && !r_err && !r_we) ? w_load_data : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit with a word memory.
//  Revision    : 1.0
// ============================================================================
module tb_mem_access_unit;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          cyc0;
        int          ce0;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_ce, mem_we, mem_rr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_w_mask, mem_r_mask;

    logic        req_valid_3, req_ready_3, req_we_3, req_unsigned_3;
    logic [1:0]  req_size_3;
    logic [31:0] req_addr_3, req_wdata_3;
    logic        resp_valid_3, resp_err_3;
    logic [31:0] resp_rdata_3;
    logic        mem_ce_3, mem_we_3, mem_rr_3;
    logic [31:0] mem_addr_3, mem_wdata_3, mem_rdata_3;
    logic [3:0]  mem_w_mask_3, mem_r_mask_3;

    logic [31:0] tb_mem [0:1023];
    logic [31:0] mem3   [0:15];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   ce_total = 0;
    exp_t sb_q[$];
    vec_t vt [0:26];

    mem_access_unit #(.READ_LAT(1), .MEM_BYTES(4096)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_rr(mem_rr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_w_mask(mem_w_mask), .mem_r_mask(mem_r_mask), .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.READ_LAT(3), .MEM_BYTES(4096)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_3), .req_ready(req_ready_3), .req_we(req_we_3),
        .req_size(req_size_3), .req_unsigned(req_unsigned_3),
        .req_addr(req_addr_3), .req_wdata(req_wdata_3),
        .resp_valid(resp_valid_3), .resp_rdata(resp_rdata_3), .resp_err(resp_err_3),
        .mem_ce(mem_ce_3), .mem_we(mem_we_3), .mem_rr(mem_rr_3),
        .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_w_mask(mem_w_mask_3), .mem_r_mask(mem_r_mask_3), .mem_rdata(mem_rdata_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_ce) ce_total <= ce_total + 1;
    end

    always @(posedge clk) begin
        if (mem_ce && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_w_mask[b]) tb_mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        if (mem_ce_3 && mem_we_3)
            for (int b = 0; b < 4; b++)
                if (mem_w_mask_3[b]) mem3[mem_addr_3[5:2]][8*b +: 8] <= mem_wdata_3[8*b +: 8];
    end

    assign mem_rdata   = tb_mem[mem_addr[11:2]];
    assign mem_rdata_3 = mem3[mem_addr_3[5:2]];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        $display("FAIL %s: bound expired, got no event expected one", name);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat;
        return v;
    endfunction

    task automatic wait_ready();
        int waited = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic run_req(input vec_t v, input int idx);
        exp_t e, got;
        bit   done = 1'b0;
        wait_ready();
        if (!req_ready) begin
            note_fail($sformatf("v%0d ready", idx));
            return;
        end
        req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.lat;
        e.cyc0 = cyc; e.ce0 = ce_total;
        sb_q.push_back(e);
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_ce) check32($sformatf("v%0d mem_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
            if (mem_we) check32($sformatf("v%0d w_mask", idx), 32'(mem_w_mask), 32'hF);
            if (mem_rr) check32($sformatf("v%0d r_mask", idx), 32'(mem_r_mask), 32'hF);
            if (resp_valid) begin
                got = sb_q.pop_front();
                check32($sformatf("v%0d rdata", idx), resp_rdata, got.rdata);
                check32($sformatf("v%0d err", idx), 32'(resp_err), 32'(got.err));
                check32($sformatf("v%0d latency", idx), 32'(cyc - got.cyc0), 32'(got.lat));
                check32($sformatf("v%0d ce cycles", idx), 32'(ce_total - got.ce0), 32'(got.lat - 1));
                done = 1'b1;
            end
        end
        if (!done) begin
            note_fail($sformatf("v%0d resp", idx));
            sb_q.delete();
        end
        @(negedge clk);
        check32($sformatf("v%0d pulse end", idx), 32'(resp_valid), 32'h0);
        check32($sformatf("v%0d idle ready", idx), 32'(req_ready), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int waited;
        vt[0]  = mk(1, 2'b10, 0, 32'h20,  32'h11223344, 32'h0,        0, 2);
        vt[1]  = mk(1, 2'b10, 0, 32'h30,  32'h80FF7F01, 32'h0,        0, 2);
        vt[2]  = mk(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2);
        vt[3]  = mk(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2);
        vt[4]  = mk(1, 2'b00, 0, 32'h22,  32'hFFFFFFAA, 32'h0,        0, 3);
        vt[5]  = mk(0, 2'b10, 0, 32'h20,  32'h0,        32'h11AA3344, 0, 2);
        vt[6]  = mk(0, 2'b00, 0, 32'h31,  32'h0,        32'h0000007F, 0, 2);
        vt[7]  = mk(0, 2'b00, 0, 32'h33,  32'h0,        32'hFFFFFF80, 0, 2);
        vt[8]  = mk(0, 2'b00, 1, 32'h33,  32'h0,        32'h00000080, 0, 2);
        vt[9]  = mk(0, 2'b01, 0, 32'h32,  32'h0,        32'hFFFF80FF, 0, 2);
        vt[10] = mk(0, 2'b01, 1, 32'h32,  32'h0,        32'h000080FF, 0, 2);
        vt[11] = mk(0, 2'b01, 0, 32'h30,  32'h0,        32'h00007F01, 0, 2);
        vt[12] = mk(0, 2'b00, 0, 32'h32,  32'h0,        32'hFFFFFFFF, 0, 2);
        vt[13] = mk(0, 2'b01, 0, 32'h13,  32'h0,        32'h0,        1, 1);
        vt[14] = mk(0, 2'b10, 0, 32'h12,  32'h0,        32'h0,        1, 1);
        vt[15] = mk(0, 2'b10, 0, 32'h1000, 32'h0,       32'h0,        1, 1);
        vt[16] = mk(1, 2'b00, 0, 32'h1000, 32'h55,      32'h0,        1, 1);
        vt[17] = mk(1, 2'b01, 0, 32'h31,  32'h1234,     32'h0,        1, 1);
        vt[18] = mk(1, 2'b01, 0, 32'h12,  32'h12345678, 32'h0,        0, 3);
        vt[19] = mk(1, 2'b00, 0, 32'h11,  32'h0000005A, 32'h0,        0, 3);
        vt[20] = mk(0, 2'b10, 0, 32'h10,  32'h0,        32'h56785AEF, 0, 2);
        vt[21] = mk(1, 2'b11, 0, 32'hFFC, 32'hCAFEF00D, 32'h0,        0, 2);
        vt[22] = mk(0, 2'b11, 0, 32'hFFC, 32'h0,        32'hCAFEF00D, 0, 2);
        vt[23] = mk(0, 2'b10, 0, 32'h30,  32'h0,        32'h80FF7F01, 0, 2);
        vt[24] = mk(1, 2'b01, 0, 32'h30,  32'hAAAABEEF, 32'h0,        0, 3);
        vt[25] = mk(0, 2'b01, 1, 32'h30,  32'h0,        32'h0000BEEF, 0, 2);
        vt[26] = mk(0, 2'b10, 0, 32'hFFFFFFFC, 32'h0,   32'h0,        1, 1);

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        req_valid_3 = 1'b0; req_we_3 = 1'b0; req_size_3 = 2'b10; req_unsigned_3 = 1'b0;
        req_addr_3 = 32'h0; req_wdata_3 = 32'h0;
        repeat (3) @(negedge clk);
        check32("rst mem_ce", 32'(mem_ce), 32'h0);
        check32("rst resp_valid", 32'(resp_valid), 32'h0);
        rst = 1'b0;
        #1;
        check32("reset req_ready", 32'(req_ready), 32'h1);
        check32("reset resp_valid", 32'(resp_valid), 32'h0);
        check32("reset resp_err", 32'(resp_err), 32'h0);
        check32("reset resp_rdata", resp_rdata, 32'h0);
        check32("reset mem strobes", {29'h0, mem_ce, mem_we, mem_rr}, 32'h0);
        check32("reset mem_addr", mem_addr, 32'h0);
        check32("reset mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);

        for (int i = 0; i < 27; i++) run_req(vt[i], i);

        check32("mem 0x10", tb_mem[4], 32'h56785AEF);
        check32("mem 0x20", tb_mem[8], 32'h11AA3344);
        check32("mem 0x30", tb_mem[12], 32'h80FFBEEF);
        check32("mem 0xFFC", tb_mem[1023], 32'hCAFEF00D);

        // Reset lands on the write cycle of a sub-word store.
        wait_ready();
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h77; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check32("t5 read phase", 32'(mem_rr), 32'h1);
        @(negedge clk);
        check32("t5 write phase", 32'(mem_we), 32'h1);
        rst = 1'b1;
        #1;
        check32("t5 we gated", 32'(mem_we), 32'h0);
        check32("t5 ce gated", 32'(mem_ce), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check32("t5 ready after rst", 32'(req_ready), 32'h1);
        for (int k = 0; k < 4; k++) begin
            check32($sformatf("t5 no resp %0d", k), 32'(resp_valid), 32'h0);
            @(negedge clk);
        end
        check32("t5 mem unchanged", tb_mem[8], 32'h11AA3344);
        run_req(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'h11AA3344, 0, 2), 100);

        // READ_LAT=3 instance: seed a word, then hold req_valid over back-to-back loads.
        check32("t6 ready", 32'(req_ready_3), 32'h1);
        req_we_3 = 1'b1; req_size_3 = 2'b10; req_addr_3 = 32'h8;
        req_wdata_3 = 32'h13579BDF; req_valid_3 = 1'b1;
        @(negedge clk);
        req_valid_3 = 1'b0;
        waited = 0;
        while (!req_ready_3 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready_3) note_fail("t6 store drain");
        req_we_3 = 1'b0; req_valid_3 = 1'b1;
        for (int k = 0; k < 11; k++) begin
            int ph;
            ph = k % 5;
            check32($sformatf("t6 ready k%0d", k), 32'(req_ready_3), 32'(ph == 0));
            check32($sformatf("t6 rr k%0d", k), 32'(mem_rr_3), 32'(ph >= 1 && ph <= 3));
            check32($sformatf("t6 resp k%0d", k), 32'(resp_valid_3), 32'(ph == 4));
            if (ph >= 1 && ph <= 3) begin
                check32($sformatf("t6 addr k%0d", k), mem_addr_3, 32'h8);
                check32($sformatf("t6 r_mask k%0d", k), 32'(mem_r_mask_3), 32'hF);
            end
            if (ph == 4) begin
                check32($sformatf("t6 rdata k%0d", k), resp_rdata_3, 32'h13579BDF);
                check32($sformatf("t6 err k%0d", k), 32'(resp_err_3), 32'h0);
            end
            @(negedge clk);
        end
        req_valid_3 = 1'b0;
        waited = 0;
        while (!req_ready_3 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready_3) note_fail("t6 load drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
